// File: rtl/csi2tx_ahb_arbiter_mod.sv
// Two-master AHB arbiter for the CSI2TX AHB verification model.
// Registered grants, hmaster/hmastlock, burst-aware and lock-aware handover.
module csi2tx_ahb_arbiter_mod #(
    parameter int         DEFAULT_MASTER = 1,
    parameter int         ARB_MODE       = 1,
    parameter logic [3:0] MASTER1_ID     = 4'b0001,
    parameter logic [3:0] MASTER2_ID     = 4'b0010
) (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       hbusreq1,
    input  logic       hbusreq2,
    input  logic       hlock1,
    input  logic       hlock2,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic       hready,
    input  logic [1:0] hresp,
    output logic       hgrant1,
    output logic       hgrant2,
    output logic [3:0] hmaster,
    output logic       hmastlock
);

    typedef enum logic [0:0] {
        OWN_M1 = 1'b0,
        OWN_M2 = 1'b1
    } state_t;

    localparam state_t     DEF_STATE = (DEFAULT_MASTER == 2) ? OWN_M2 : OWN_M1;
    localparam logic [3:0] DEF_ID    = (DEFAULT_MASTER == 2) ? MASTER2_ID : MASTER1_ID;

    state_t     state_r;
    state_t     next_state_s;
    state_t     winner_s;
    logic [3:0] burst_cnt_r;
    logic [3:0] burst_cnt_next_s;
    logic       owner_lock_s;
    logic       retry_first_s;
    logic       rearb_ok_s;

    // Lock of the current owner and first cycle of a RETRY/SPLIT response
    always_comb begin
        if (state_r == OWN_M2) begin
            owner_lock_s = hlock2;
        end else begin
            owner_lock_s = hlock1;
        end
        retry_first_s = ((hresp == 2'b10) || (hresp == 2'b11)) && !hready;
        rearb_ok_s    = (!owner_lock_s || retry_first_s) && (burst_cnt_r == 4'd0);
    end

    // Winner selection; in round-robin the non-owner wins a tie
    always_comb begin
        winner_s = DEF_STATE;
        case ({hbusreq1, hbusreq2})
            2'b11: begin
                if (ARB_MODE == 0) begin
                    winner_s = OWN_M1;
                end else if (state_r == OWN_M1) begin
                    winner_s = OWN_M2;
                end else begin
                    winner_s = OWN_M1;
                end
            end
            2'b10:   winner_s = OWN_M1;
            2'b01:   winner_s = OWN_M2;
            default: winner_s = DEF_STATE;
        endcase
    end

    // Next-state: move to the winner only on a ready edge with no burst/lock pending
    always_comb begin
        next_state_s = state_r;
        if (hready && rearb_ok_s) begin
            next_state_s = winner_s;
        end else begin
            next_state_s = state_r;
        end
    end

    // Remaining-beat counter; a NONSEQ load takes precedence over handover
    always_comb begin
        burst_cnt_next_s = burst_cnt_r;
        if (retry_first_s) begin
            burst_cnt_next_s = 4'd0;
        end else if (hready) begin
            case (htrans)
                2'b10: begin
                    case (hburst)
                        3'b010, 3'b011: burst_cnt_next_s = 4'd3;
                        3'b100, 3'b101: burst_cnt_next_s = 4'd7;
                        3'b110, 3'b111: burst_cnt_next_s = 4'd15;
                        default:        burst_cnt_next_s = 4'd0;
                    endcase
                end
                2'b11: begin
                    if (burst_cnt_r != 4'd0) begin
                        burst_cnt_next_s = burst_cnt_r - 4'd1;
                    end else begin
                        burst_cnt_next_s = 4'd0;
                    end
                end
                default: burst_cnt_next_s = burst_cnt_r;
            endcase
        end else begin
            burst_cnt_next_s = burst_cnt_r;
        end
    end

    // State, counter and owner indication registers
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_r     <= DEF_STATE;
            burst_cnt_r <= 4'd0;
            hmaster     <= DEF_ID;
            hmastlock   <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            burst_cnt_r <= burst_cnt_next_s;
            if (hready) begin
                hmaster   <= (state_r == OWN_M2) ? MASTER2_ID : MASTER1_ID;
                hmastlock <= owner_lock_s;
            end
        end
    end

    // Grant decode straight from the state register
    always_comb begin
        hgrant1 = (state_r == OWN_M1);
        hgrant2 = (state_r == OWN_M2);
    end

endmodule

// File: tb/tb_csi2tx_ahb_arbiter_mod.sv
// Directed bench for csi2tx_ahb_arbiter_mod with a cycle-level reference model.
module tb_csi2tx_ahb_arbiter_mod;

    logic       hclk = 1'b0;
    logic       hresetn = 1'b0;
    logic       hbusreq1 = 1'b0, hbusreq2 = 1'b0, hlock1 = 1'b0, hlock2 = 1'b0;
    logic [1:0] htrans = 2'b00;
    logic [2:0] hburst = 3'b000;
    logic       hready = 1'b1;
    logic [1:0] hresp = 2'b00;
    logic       hgrant1, hgrant2, hmastlock;
    logic [3:0] hmaster;

    int errors = 0;
    int checks = 0;

    csi2tx_ahb_arbiter_mod #(
        .DEFAULT_MASTER(1),
        .ARB_MODE(1),
        .MASTER1_ID(4'b0001),
        .MASTER2_ID(4'b0010)
    ) dut (
        .hclk(hclk), .hresetn(hresetn),
        .hbusreq1(hbusreq1), .hbusreq2(hbusreq2),
        .hlock1(hlock1), .hlock2(hlock2),
        .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
        .hgrant1(hgrant1), .hgrant2(hgrant2),
        .hmaster(hmaster), .hmastlock(hmastlock)
    );

    always #5 hclk = ~hclk;

    // Reference model: owner number, beats still to come, owner indication
    int         m_owner = 1;
    int         m_rem   = 0;
    logic [3:0] m_id    = 4'b0001;
    logic       m_lock  = 1'b0;
    int         len_tab [4] = '{0, 3, 7, 15};

    function automatic bit first_retry();
        return (hresp >= 2'd2) && !hready;
    endfunction

    function automatic bit may_switch();
        bit holding;
        holding = ((m_owner == 1) ? hlock1 : hlock2) && !first_retry();
        return hready && !holding && (m_rem == 0);
    endfunction

    function automatic int winner();
        if (hbusreq1 && hbusreq2) return (m_owner == 1) ? 2 : 1;
        if (hbusreq1) return 1;
        if (hbusreq2) return 2;
        return 1;
    endfunction

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            m_owner <= 1;
            m_rem   <= 0;
            m_id    <= 4'b0001;
            m_lock  <= 1'b0;
        end else begin
            if (may_switch()) m_owner <= winner();
            if (hready) begin
                m_id   <= (m_owner == 1) ? 4'b0001 : 4'b0010;
                m_lock <= (m_owner == 1) ? hlock1 : hlock2;
            end
            if (first_retry()) m_rem <= 0;
            else if (hready && htrans == 2'b10) m_rem <= len_tab[hburst[2:1]];
            else if (hready && htrans == 2'b11 && m_rem > 0) m_rem <= m_rem - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge hclk) begin
        check("model_hgrant1", {31'd0, hgrant1}, {31'd0, m_owner == 1});
        check("model_hgrant2", {31'd0, hgrant2}, {31'd0, m_owner == 2});
        check("model_hmaster", {28'd0, hmaster}, {28'd0, m_id});
        check("model_hmastlock", {31'd0, hmastlock}, {31'd0, m_lock});
    end

    task automatic drive(input logic r1, input logic r2, input logic l1, input logic l2,
                         input logic [1:0] tr, input logic [2:0] bu,
                         input logic rdy, input logic [1:0] rs);
        hbusreq1 = r1; hbusreq2 = r2; hlock1 = l1; hlock2 = l2;
        htrans = tr; hburst = bu; hready = rdy; hresp = rs;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    task automatic pin(input string name, input logic g1, input logic [3:0] hm, input logic ml);
        check({name, "_hgrant1"}, {31'd0, hgrant1}, {31'd0, g1});
        check({name, "_hgrant2"}, {31'd0, hgrant2}, {31'd0, !g1});
        check({name, "_hmaster"}, {28'd0, hmaster}, {28'd0, hm});
        check({name, "_hmastlock"}, {31'd0, hmastlock}, {31'd0, ml});
    endtask

    initial begin
        // Reset with nobody requesting
        tick(2);
        pin("reset", 1'b1, 4'b0001, 1'b0);
        hresetn = 1'b1;

        // Round-robin alternation with single transfers
        drive(1, 1, 0, 0, 2'b10, 3'b000, 1, 2'b00);
        tick(1); pin("rr1", 1'b0, 4'b0001, 1'b0);
        tick(1); pin("rr2", 1'b1, 4'b0010, 1'b0);
        tick(1); pin("rr3", 1'b0, 4'b0001, 1'b0);

        // INCR4 burst by master 2; master 1 requests during the SEQ beats
        drive(0, 1, 0, 0, 2'b00, 3'b000, 1, 2'b00); tick(1);
        drive(0, 1, 0, 0, 2'b10, 3'b011, 1, 2'b00); tick(1);
        drive(1, 1, 0, 0, 2'b11, 3'b011, 1, 2'b00);
        tick(1); pin("incr4_seq1", 1'b0, 4'b0010, 1'b0);
        tick(1); pin("incr4_seq2", 1'b0, 4'b0010, 1'b0);
        tick(1); pin("incr4_seq3", 1'b0, 4'b0010, 1'b0);
        drive(1, 0, 0, 0, 2'b00, 3'b000, 1, 2'b00);
        tick(1); pin("incr4_done", 1'b1, 4'b0010, 1'b0);
        tick(1); pin("incr4_hm", 1'b1, 4'b0001, 1'b0);

        // Locked sequence by master 1 while master 2 waits
        drive(1, 1, 1, 0, 2'b10, 3'b000, 1, 2'b00);
        tick(1); pin("lock1", 1'b1, 4'b0001, 1'b1);
        tick(5); pin("lock6", 1'b1, 4'b0001, 1'b1);
        drive(0, 1, 0, 0, 2'b00, 3'b000, 1, 2'b00);
        tick(1); pin("lock_release", 1'b0, 4'b0001, 1'b0);

        // RETRY on beat 3 of an INCR8 by master 2
        drive(0, 1, 0, 0, 2'b10, 3'b101, 1, 2'b00); tick(1);
        drive(1, 1, 0, 0, 2'b11, 3'b101, 1, 2'b00); tick(2);
        drive(1, 1, 0, 0, 2'b11, 3'b101, 0, 2'b10);
        tick(1); pin("retry_c1", 1'b0, 4'b0010, 1'b0);
        drive(1, 0, 0, 0, 2'b00, 3'b101, 1, 2'b10);
        tick(1); pin("retry_c2", 1'b1, 4'b0010, 1'b0);

        // hready stall with a pending request from master 2
        drive(0, 1, 0, 0, 2'b00, 3'b000, 0, 2'b00);
        tick(4); pin("stall4", 1'b1, 4'b0010, 1'b0);
        hready = 1'b1;
        tick(1); pin("stall_end", 1'b0, 4'b0001, 1'b0);

        // Reset in the middle of an INCR16
        drive(0, 1, 0, 0, 2'b10, 3'b111, 1, 2'b00); tick(1);
        drive(1, 1, 0, 0, 2'b11, 3'b111, 1, 2'b00); tick(1);
        hresetn = 1'b0;
        #1; pin("midreset", 1'b1, 4'b0001, 1'b0);
        drive(1, 0, 0, 0, 2'b00, 3'b000, 1, 2'b00);
        tick(1);
        hresetn = 1'b1;

        // ERROR response must not clear the burst counter
        drive(1, 0, 0, 0, 2'b10, 3'b011, 1, 2'b00); tick(1);
        drive(0, 1, 0, 0, 2'b11, 3'b011, 1, 2'b00); tick(1);
        drive(0, 1, 0, 0, 2'b11, 3'b011, 0, 2'b01); tick(1);
        drive(0, 1, 0, 0, 2'b00, 3'b011, 1, 2'b01);
        tick(1); pin("error_hold", 1'b1, 4'b0001, 1'b0);
        drive(0, 1, 0, 0, 2'b11, 3'b011, 1, 2'b00); tick(2);
        drive(0, 1, 0, 0, 2'b00, 3'b000, 1, 2'b00);
        tick(1); pin("error_done", 1'b0, 4'b0001, 1'b0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
